// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_if
// Description : Handshake bundle between the fetch stage, the operand fetch
//               stage, the shared-bus control/response lines and the execute
//               stage. The tri-stated bus lines (addr, read_q) are kept as
//               plain module ports so they resolve on ordinary nets.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] command;
  logic [ADDR_W-1:0] base_addr;
  logic              disp_online;
  logic              is_bus_busy;
  logic              read_dn;
  logic [DATA_W-1:0] data;
  logic [4:0]        op;
  logic [DATA_W-1:0] src0;
  logic [DATA_W-1:0] src1;
  logic [ADDR_W-1:0] dst_addr;
  logic              busy;
  logic              done;

  // Operand fetch stage side
  modport master (
    input  start, command, base_addr, disp_online, is_bus_busy, read_dn, data,
    output op, src0, src1, dst_addr, busy, done
  );

  // Environment side (fetch stage, bus, execute stage)
  modport slave (
    output start, command, base_addr, disp_online, is_bus_busy, read_dn, data,
    input  op, src0, src1, dst_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decodes the operand fields of a fetched command, reads the
//               source registers (optionally dereferenced as pointers) over
//               the shared memory bus and presents resolved operands and the
//               destination address to the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  wire               clk,
  input  wire               rst,
  operand_fetch_if.master   bus,
  inout  wire  [ADDR_W-1:0] addr,
  output wire               read_q
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_RD_S0  = 3'd2;
  localparam logic [2:0] S_RD_S0P = 3'd3;
  localparam logic [2:0] S_RD_S1  = 3'd4;
  localparam logic [2:0] S_RD_S1P = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              wait_q;      // 0: request phase, 1: waiting for read_dn
  logic [3:0]        ctl_q;       // {s1_ptr, s0_ptr, use_s1, use_s0}
  logic [IDX_W-1:0]  dst_idx_q;
  logic [IDX_W-1:0]  s0_idx_q;
  logic [IDX_W-1:0]  s1_idx_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] ptr_q;       // pointer fetched by RD_S0 / RD_S1
  logic [ADDR_W-1:0] dst_q;
  logic [4:0]        op_q;
  logic [DATA_W-1:0] src0_q;
  logic [DATA_W-1:0] src1_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] w_s0_addr;
  logic [ADDR_W-1:0] w_s1_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [2:0]        w_first;
  logic [2:0]        w_after_s0;
  logic              w_rd_state;
  logic              w_req_fire;
  logic              w_rsp_hit;
  logic              w_unused;

  // Command bits that carry no meaning for this stage
  assign w_unused = ^bus.command[22:12];

  // Register addresses wrap modulo 2^ADDR_W
  assign w_s0_addr = base_q + {{(ADDR_W-IDX_W){1'b0}}, s0_idx_q};
  assign w_s1_addr = base_q + {{(ADDR_W-IDX_W){1'b0}}, s1_idx_q};

  assign w_after_s0 = ctl_q[1] ? S_RD_S1 : S_DONE;
  assign w_first    = ctl_q[0] ? S_RD_S0 : w_after_s0;

  assign w_rd_state = (state_q == S_RD_S0) || (state_q == S_RD_S0P) ||
                      (state_q == S_RD_S1) || (state_q == S_RD_S1P);

  // Request goes out only when the dispatcher grants and the bus is idle
  assign w_req_fire = w_rd_state && !wait_q && bus.disp_online && !bus.is_bus_busy;
  // A completion counts only if it answers our own address
  assign w_rsp_hit  = w_rd_state && wait_q && bus.read_dn && (addr == w_rd_addr);

  assign addr   = w_req_fire ? w_rd_addr : {ADDR_W{1'bz}};
  assign read_q = w_req_fire ? 1'b1 : 1'bz;

  assign bus.op       = op_q;
  assign bus.src0     = src0_q;
  assign bus.src1     = src1_q;
  assign bus.dst_addr = dst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Address of the read belonging to the current state
  always_comb begin
    w_rd_addr = ptr_q;
    case (state_q)
      S_RD_S0: w_rd_addr = w_s0_addr;
      S_RD_S1: w_rd_addr = w_s1_addr;
      default: w_rd_addr = ptr_q;
    endcase
  end

  // Next-state selection; read states advance only on a matching completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_DECODE;
      S_DECODE: state_d = w_first;
      S_RD_S0:  if (w_rsp_hit) state_d = ctl_q[2] ? S_RD_S0P : w_after_s0;
      S_RD_S0P: if (w_rsp_hit) state_d = w_after_s0;
      S_RD_S1:  if (w_rsp_hit) state_d = ctl_q[3] ? S_RD_S1P : S_DONE;
      S_RD_S1P: if (w_rsp_hit) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, phase, latched command fields and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 1'b0;
      ctl_q     <= '0;
      dst_idx_q <= '0;
      s0_idx_q  <= '0;
      s1_idx_q  <= '0;
      base_q    <= '0;
      ptr_q     <= '0;
      dst_q     <= '0;
      op_q      <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);

      if (w_req_fire) begin
        wait_q <= 1'b1;
      end else if (w_rsp_hit) begin
        wait_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q      <= bus.command[31:27];
            ctl_q     <= bus.command[26:23];
            dst_idx_q <= bus.command[8 +: IDX_W];
            s0_idx_q  <= bus.command[4 +: IDX_W];
            s1_idx_q  <= bus.command[0 +: IDX_W];
            base_q    <= bus.base_addr;
          end
        end
        S_DECODE: begin
          dst_q  <= base_q + {{(ADDR_W-IDX_W){1'b0}}, dst_idx_q};
          src0_q <= '0;
          src1_q <= '0;
        end
        S_RD_S0: begin
          if (w_rsp_hit) begin
            if (ctl_q[2]) ptr_q  <= bus.data[ADDR_W-1:0];
            else          src0_q <= bus.data;
          end
        end
        S_RD_S0P: if (w_rsp_hit) src0_q <= bus.data;
        S_RD_S1: begin
          if (w_rsp_hit) begin
            if (ctl_q[3]) ptr_q  <= bus.data[ADDR_W-1:0];
            else          src1_q <= bus.data;
          end
        end
        S_RD_S1P: if (w_rsp_hit) src1_q <= bus.data;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch: directed vector table,
//               hand-written corner sequences and randomized commands against
//               a behavioural reference model with a bus/memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  wire [AW-1:0] addr;
  wire          read_q;
  logic         tb_drv = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  assign addr = tb_drv ? tb_addr : {AW{1'bz}};

  operand_fetch #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .addr  (addr),
    .read_q(read_q)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // memory contents seen by the bus responder and the model
  logic [31:0] mem [logic [31:0]];

  // responder controls
  int          resp_delay   = 0;
  bit          rand_mode    = 0;
  bit          stray_en     = 0;
  logic [31:0] stray_addr   = '0;
  int          busy_hold    = 0;
  int          offline_hold = 0;
  bit          pend_v       = 0;
  int          pend_cnt     = 0;
  logic [31:0] pend_a       = '0;
  logic [31:0] req_log [$];

  // model outputs
  logic [4:0]  m_op;
  logic [31:0] m_dst, m_s0, m_s1;
  logic [31:0] m_addr [4];
  int          m_n, m_lat;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] base;
    logic [4:0]  op;
    logic [31:0] dst;
    logic [31:0] s0;
    logic [31:0] s1;
    int          lat;
    int          nreq;
    bit          sid;   // also try a start in the DONE cycle
  } vec_t;
  vec_t vec [6];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Operand resolution straight from the command field rules
  function automatic void model(input logic [31:0] cmd, input logic [31:0] base);
    logic [31:0] a, v;
    m_op  = cmd[31:27];
    m_dst = base + 32'(cmd[11:8]);
    m_s0  = '0;
    m_s1  = '0;
    m_n   = 0;
    if (cmd[23]) begin
      a = base + 32'(cmd[7:4]);
      m_addr[m_n] = a; m_n++;
      v = mem_rd(a);
      if (cmd[25]) begin m_addr[m_n] = v; m_n++; v = mem_rd(v); end
      m_s0 = v;
    end
    if (cmd[24]) begin
      a = base + 32'(cmd[3:0]);
      m_addr[m_n] = a; m_n++;
      v = mem_rd(a);
      if (cmd[26]) begin m_addr[m_n] = v; m_n++; v = mem_rd(v); end
      m_s1 = v;
    end
    m_lat = 2 + 2 * m_n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Bus responder / memory: acts 2 time units after each rising edge
  initial begin
    bus.read_dn = 1'b0; bus.data = '0; bus.is_bus_busy = 1'b0; bus.disp_online = 1'b1;
    forever begin
      @(posedge clk); #2;
      tb_drv = 1'b0; bus.read_dn = 1'b0; bus.data = $urandom;
      if (busy_hold > 0) begin
        bus.is_bus_busy = 1'b1; bus.disp_online = 1'b1; busy_hold--;
      end else if (offline_hold > 0) begin
        bus.is_bus_busy = 1'b0; bus.disp_online = 1'b0; offline_hold--;
      end else if (rand_mode) begin
        bus.is_bus_busy = ($urandom_range(0, 3) == 0);
        bus.disp_online = ($urandom_range(0, 4) != 0);
      end else begin
        bus.is_bus_busy = 1'b0; bus.disp_online = 1'b1;
      end
      if (pend_v) begin
        if (pend_cnt == 0) begin
          tb_drv = 1'b1; tb_addr = pend_a; bus.read_dn = 1'b1; bus.data = mem_rd(pend_a);
          pend_v = 1'b0;
        end else begin
          if (stray_en || (rand_mode && $urandom_range(0, 2) == 0)) begin
            tb_drv = 1'b1;
            tb_addr = stray_en ? stray_addr : (pend_a ^ (32'h1 << $urandom_range(0, 31)));
            bus.read_dn = 1'b1; bus.data = 32'hDEAD_BEEF;
            stray_en = 1'b0;
          end
          pend_cnt--;
        end
      end
      #1;
      if (read_q === 1'b1) begin
        req_log.push_back(addr);
        pend_v = 1'b1; pend_a = addr;
        pend_cnt = rand_mode ? int'($urandom_range(0, 3)) : resp_delay;
      end
    end
  end

  // Issue one command and wait for done; lat = cycles from start to done
  task automatic run_op(input logic [31:0] cmd, input logic [31:0] base,
                        input int restart_at, input int noreq_at, output int lat);
    req_log.delete();
    bus.command = cmd; bus.base_addr = base; bus.start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      cyc();
      bus.start = 1'b0;
      if (n == 1) check("busy_after_start", bus.busy, 1);
      if (n == noreq_at) check("no_req_while_blocked", req_log.size(), 0);
      if (n == restart_at) begin
        bus.start = 1'b1; bus.command = 32'hFFFF_FFFF; bus.base_addr = 32'h0000_DEAD;
      end
      if (bus.done === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic start_in_done();
    bus.start = 1'b1; bus.command = 32'h0180_0312; bus.base_addr = 32'h200;
    cyc();
    bus.start = 1'b0;
    check("done_single_pulse", bus.done, 0);
    check("start_in_done_busy", bus.busy, 0);
    cyc();
    check("start_in_done_idle", bus.busy, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [31:0] cmd, base;

    rst = 1'b1; bus.start = 1'b0; bus.command = '0; bus.base_addr = '0;
    mem[32'h201] = 32'hAA;   mem[32'h202] = 32'hBB;
    mem[32'h5]   = 32'h40;   mem[32'h40]  = 32'h1234;
    mem[32'h3]   = 32'h33;
    mem[32'h301] = 32'h50;   mem[32'h50]  = 32'h5555;
    mem[32'h302] = 32'h60;   mem[32'h60]  = 32'h6666;

    vec[0] = '{32'hF800_0000, 32'h100,       5'h1F, 32'h100,  32'h0,    32'h0,    2,  0, 1};
    vec[1] = '{32'h0180_0312, 32'h200,       5'h00, 32'h203,  32'hAA,   32'hBB,   6,  2, 0};
    vec[2] = '{32'h0280_0050, 32'h0,         5'h00, 32'h0,    32'h1234, 32'h0,    6,  2, 0};
    vec[3] = '{32'h0C00_0A00, 32'h100,       5'h01, 32'h10A,  32'h0,    32'h0,    2,  0, 1};
    vec[4] = '{32'h0100_0F05, 32'hFFFF_FFFE, 5'h00, 32'hD,    32'h0,    32'h33,   4,  1, 0};
    vec[5] = '{32'h0780_0012, 32'h300,       5'h00, 32'h300,  32'h5555, 32'h6666, 10, 4, 0};

    idle(3);
    check("rst_op", bus.op, 0);
    check("rst_src0", bus.src0, 0);
    check("rst_src1", bus.src1, 0);
    check("rst_dst", bus.dst_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_read_q", (read_q === 1'b1), 0);
    rst = 1'b0;
    idle(2);

    // directed vector table
    foreach (vec[i]) begin
      run_op(vec[i].cmd, vec[i].base, -1, -1, lat);
      check($sformatf("v%0d_op", i), bus.op, vec[i].op);
      check($sformatf("v%0d_dst", i), bus.dst_addr, vec[i].dst);
      check($sformatf("v%0d_src0", i), bus.src0, vec[i].s0);
      check($sformatf("v%0d_src1", i), bus.src1, vec[i].s1);
      check($sformatf("v%0d_lat", i), lat, vec[i].lat);
      check($sformatf("v%0d_nreq", i), req_log.size(), vec[i].nreq);
      if (vec[i].sid) start_in_done();
      else idle(1);
    end

    // stray completion for a foreign address plus a second start while busy
    resp_delay = 2; stray_addr = 32'h999; stray_en = 1'b1;
    run_op(32'h0180_0312, 32'h200, 3, -1, lat);
    check("stray_src0", bus.src0, 32'hAA);
    check("stray_src1", bus.src1, 32'hBB);
    check("stray_dst", bus.dst_addr, 32'h203);
    check("stray_lat", lat, 10);
    check("stray_nreq", req_log.size(), 2);
    check("stray_req0", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h201);
    check("stray_req1", (req_log.size() > 1) ? req_log[1] : 32'hFFFF_FFFF, 32'h202);
    resp_delay = 0;
    idle(2);

    // bus contention: busy for 5 cycles, then dispatcher offline for 3
    busy_hold = 5; offline_hold = 3;
    run_op(32'h0080_0010, 32'h200, -1, 8, lat);
    check("cont_lat", lat, 10);
    check("cont_nreq", req_log.size(), 1);
    check("cont_req0", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h201);
    check("cont_src0", bus.src0, 32'hAA);
    idle(2);

    // reset while waiting for the second operand, then a late completion
    resp_delay = 4;
    req_log.delete();
    bus.command = 32'h0180_0312; bus.base_addr = 32'h200; bus.start = 1'b1;
    for (int n = 0; n < 100 && req_log.size() < 2; n++) begin
      cyc();
      bus.start = 1'b0;
    end
    check("rstmid_reached_s1", req_log.size(), 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_src0", bus.src0, 0);
    check("rstmid_dst", bus.dst_addr, 0);
    check("rstmid_read_q", (read_q === 1'b1), 0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (bus.done === 1'b1 || bus.busy === 1'b1 || bus.src1 !== 32'h0) seen++;
    end
    check("rstmid_late_dn_ignored", seen, 0);
    resp_delay = 0;
    run_op(vec[1].cmd, vec[1].base, -1, -1, lat);
    check("after_rst_src0", bus.src0, 32'hAA);
    check("after_rst_src1", bus.src1, 32'hBB);
    check("after_rst_lat", lat, 6);
    idle(2);

    // reset and start together: reset wins
    rst = 1'b1; bus.start = 1'b1; bus.command = 32'h0180_0312; bus.base_addr = 32'h200;
    cyc();
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start_busy0", bus.busy, 0);
    cyc();
    check("rst_start_busy1", bus.busy, 0);
    idle(1);

    // randomized commands with random stalls, delays and strays
    rand_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      cmd  = $urandom;
      base = (t % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      model(cmd, base);
      run_op(cmd, base, -1, -1, lat);
      check("rand_op", bus.op, m_op);
      check("rand_dst", bus.dst_addr, m_dst);
      check("rand_src0", bus.src0, m_s0);
      check("rand_src1", bus.src1, m_s1);
      check("rand_lat_min", (lat >= m_lat), 1);
      check("rand_nreq", req_log.size(), m_n);
      for (int k = 0; k < m_n && k < req_log.size(); k++)
        check($sformatf("rand_req%0d", k), req_log[k], m_addr[k]);
      idle(1 + $urandom_range(0, 2));
    end
    rand_mode = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
